apb_rr_master_arbiter: RTL and testbench

Shares one APB3 master port between NREQ on-chip requesters, using round-robin arbitration.
- Each requester presents a simple valid/ready command (address, write flag, write data).
- The block sequences the APB SETUP/ACCESS phases itself and returns read data and error status to the granted requester.
- A wait-state watchdog aborts transfers to hung slaves.
- Sits between the bus-side agents and the existing APB slave interface.

---
 rtl/apb_rr_master_arbiter.sv | 169 ++++++++++++++++
 tb/tb_apb_rr_master_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter that shares one APB3 master port between NREQ requesters.
// It sequences SETUP/ACCESS itself and aborts transfers to slaves that stall too long.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | bus idle; arbitrate and accept one command
// S_SETUP  | APB setup phase (PSEL=1, PENABLE=0), always one cycle
// S_ACCESS | APB access phase; wait for PREADY or the watchdog
module apb_rr_master_arbiter #(
   parameter int NREQ    = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                     PCLK,
   input  logic                     PRESETn,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_ready,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic                     rsp_timeout,
   output logic                     PSEL,
   output logic                     PENABLE,
   output logic                     PWRITE,
   output logic [ADDR_W-1:0]        PADDR,
   output logic [DATA_W-1:0]        PWDATA,
   input  logic [DATA_W-1:0]        PRDATA,
   input  logic                     PREADY,
   input  logic                     PSLVERR
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_timeout_q, rsp_timeout_d;

   logic                found;
   logic [PTR_W-1:0]    winner;

   // Search starts one past the last grant so the previous winner goes last.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         logic [PTR_W-1:0] idx;
         idx = PTR_W'((int'(ptr_q) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = '0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      req_ready     = '0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               req_ready[winner] = 1'b1;
               state_d   = S_SETUP;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = req_write[winner];
               paddr_d   = req_addr[int'(winner)*ADDR_W +: ADDR_W];
               pwdata_d  = req_wdata[int'(winner)*DATA_W +: DATA_W];
               ptr_d     = winner;
               cnt_d     = '0;
            end
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
         end
         S_ACCESS: begin
            if (PREADY) begin
               state_d            = S_IDLE;
               psel_d             = 1'b0;
               penable_d          = 1'b0;
               rsp_valid_d[ptr_q] = 1'b1;
               rsp_rdata_d        = pwrite_q ? '0 : PRDATA;
               rsp_err_d          = PSLVERR;
               rsp_timeout_d      = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // This stalled cycle is the TIMEOUT-th one: abort.
               state_d            = S_IDLE;
               psel_d             = 1'b0;
               penable_d          = 1'b0;
               rsp_valid_d[ptr_q] = 1'b1;
               rsp_rdata_d        = '0;
               rsp_err_d          = 1'b1;
               rsp_timeout_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q       <= S_IDLE;
         ptr_q         <= PTR_W'(NREQ - 1);
         cnt_q         <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: requester drivers, an APB slave model and a
// response scoreboard filled at each accepted command.
module tb_apb_rr_master_arbiter;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
   } cmd_t;

   typedef struct {
      int          r;
      logic [31:0] rd;
      logic        e;
      logic        t;
   } exp_t;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;

   int          checks = 0;
   int          failures = 0;
   int          slv_wait = 0;
   int          acc_cnt = 0;
   logic [31:0] err_addr = 32'hFFFF_FFF0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;
   logic [1:0]  hs_n = '0;

   cmd_t cmd_q0[$];
   cmd_t cmd_q1[$];
   exp_t exp_q[$];
   int   grant_log[$];

   apb_rr_master_arbiter #(.NREQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return (a == 32'h20) ? 32'h55 : (a ^ 32'h5A5A_0000);
   endfunction

   function automatic bit busy();
      return exp_q.size() != 0 || cmd_q0.size() != 0 || cmd_q1.size() != 0 || req_valid != 2'b00;
   endfunction

   function automatic void push_cmd(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
      cmd_t c;
      c.w = w; c.a = a; c.d = d;
      if (i == 0) cmd_q0.push_back(c);
      else        cmd_q1.push_back(c);
   endfunction

   function automatic void accept(input int i);
      cmd_t c;
      exp_t e;
      c = (i == 0) ? cmd_q0.pop_front() : cmd_q1.pop_front();
      e.r = i;
      if (slv_wait < 0) begin
         e.rd = '0; e.e = 1'b1; e.t = 1'b1;
      end else begin
         e.rd = c.w ? 32'h0 : rd_model(c.a);
         e.e  = (c.a == err_addr);
         e.t  = 1'b0;
      end
      exp_q.push_back(e);
      grant_log.push_back(i);
   endfunction

   function automatic void present(input int i);
      cmd_t c;
      if ((i == 0 && cmd_q0.size() != 0) || (i == 1 && cmd_q1.size() != 0)) begin
         c = (i == 0) ? cmd_q0[0] : cmd_q1[0];
         req_valid[i]          = 1'b1;
         req_write[i]          = c.w;
         req_addr[i*32 +: 32]  = c.a;
         req_wdata[i*32 +: 32] = c.d;
      end else begin
         req_valid[i]          = 1'b0;
         req_write[i]          = 1'b0;
         req_addr[i*32 +: 32]  = '0;
         req_wdata[i*32 +: 32] = '0;
      end
   endfunction

   // Requester drivers: retire the command accepted at this edge, present the next.
   always @(posedge PCLK) begin
      #1;
      if (hs_n[0]) accept(0);
      if (hs_n[1]) accept(1);
      hs_n = '0;
      present(0);
      present(1);
   end

   // APB slave: PREADY/PSLVERR are also driven high in SETUP and junk is driven during waits.
   always @(negedge PCLK) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
         if (slv_wait >= 0 && acc_cnt == slv_wait) begin
            PREADY  = 1'b1;
            PSLVERR = (PADDR == err_addr);
            PRDATA  = rd_model(PADDR);
            if (PWRITE) begin
               last_waddr = PADDR;
               last_wdata = PWDATA;
            end
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b1;
            PRDATA  = 32'hBAD0_BAD0;
         end
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         PREADY  = (PSEL === 1'b1);
         PSLVERR = (PSEL === 1'b1);
         PRDATA  = 32'hBAD1_BAD1;
      end
   end

   // Handshake capture, one-hot ready check and response scoreboard.
   always @(negedge PCLK) begin
      exp_t e;
      hs_n = req_valid & req_ready & {2{PRESETn}};
      if (req_ready != 2'b00) begin
         checks++;
         if ($countones(req_ready) > 1) begin
            failures++;
            $display("FAIL ready_onehot got=%b required=one-hot", req_ready);
         end
      end
      if (PRESETn === 1'b1 && rsp_valid !== 2'b00) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected got rsp_valid=%b required=no response", rsp_valid);
         end else begin
            e = exp_q.pop_front();
            if (rsp_valid !== (2'b01 << e.r) || rsp_rdata !== e.rd || rsp_err !== e.e || rsp_timeout !== e.t) begin
               failures++;
               $display("FAIL rsp_scoreboard got v=%b rd=%h err=%b to=%b required v=%b rd=%h err=%b to=%b",
                        rsp_valid, rsp_rdata, rsp_err, rsp_timeout, 2'b01 << e.r, e.rd, e.e, e.t);
            end
         end
      end
   end

   task automatic test_reset();
      PRESETn = 1'b0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      checks++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus got psel=%b pen=%b pw=%b paddr=%h pwdata=%h required all 0",
                  PSEL, PENABLE, PWRITE, PADDR, PWDATA);
      end
      checks++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_rsp got v=%b rd=%h err=%b to=%b required all 0",
                  rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
      end
      PRESETn = 1'b1;
      @(negedge PCLK);
   endtask

   task automatic test_single_write();
      bit hs = 0;
      slv_wait = 0;
      push_cmd(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      for (int c = 0; c < 20; c++) begin
         @(negedge PCLK);
         if (req_valid[0] && req_ready[0]) begin hs = 1; break; end
      end
      checks++;
      if (!hs) begin failures++; $display("FAIL write_accept got=no handshake required=handshake"); end
      @(negedge PCLK);
      checks++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h10 || PWRITE !== 1'b1 || PWDATA !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL write_setup got psel=%b pen=%b paddr=%h pw=%b pwdata=%h required 1 0 10 1 deadbeef",
                  PSEL, PENABLE, PADDR, PWRITE, PWDATA);
      end
      @(negedge PCLK);
      checks++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
         failures++;
         $display("FAIL write_access got psel=%b pen=%b required 1 1", PSEL, PENABLE);
      end
      @(negedge PCLK);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || PSEL !== 1'b0) begin
         failures++;
         $display("FAIL write_rsp_cycle3 got v=%b err=%b psel=%b required 01 0 0", rsp_valid, rsp_err, PSEL);
      end
      checks++;
      if (last_waddr !== 32'h10 || last_wdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL write_slave_view got addr=%h data=%h required 10 deadbeef", last_waddr, last_wdata);
      end
   endtask

   task automatic test_read_wait();
      bit hs = 0;
      int pen = 0;
      slv_wait = 3;
      push_cmd(1, 1'b0, 32'h20, 32'h0);
      for (int c = 0; c < 20; c++) begin
         @(negedge PCLK);
         if (req_valid[1] && req_ready[1]) begin hs = 1; break; end
      end
      checks++;
      if (!hs) begin failures++; $display("FAIL read_accept got=no handshake required=handshake"); end
      for (int c = 0; c < 40; c++) begin
         @(negedge PCLK);
         if (rsp_valid != 2'b00) break;
         if (PENABLE) pen++;
      end
      checks++;
      if (pen != 4) begin failures++; $display("FAIL read_penable_cycles got=%0d required=4", pen); end
      checks++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h55 || rsp_timeout !== 1'b0) begin
         failures++;
         $display("FAIL read_rsp got v=%b rd=%h to=%b required 10 00000055 0", rsp_valid, rsp_rdata, rsp_timeout);
      end
   endtask

   task automatic test_back_to_back();
      bit started = 0;
      int gap = 0;
      logic [31:0] a0, a1;
      slv_wait = 0;
      grant_log.delete();
      for (int k = 0; k < 3; k++) begin
         a0 = 32'h100 + 32'(k * 4);
         a1 = 32'h200 + 32'(k * 4);
         push_cmd(0, 1'b0, a0, 32'h0);
         push_cmd(1, 1'b0, a1, 32'h0);
      end
      for (int c = 0; c < 100 && busy(); c++) begin
         @(negedge PCLK);
         if (PSEL) begin
            if (started && gap > 0) begin
               checks++;
               if (gap != 1) begin failures++; $display("FAIL b2b_psel_gap got=%0d required=1", gap); end
            end
            started = 1;
            gap = 0;
         end else if (started) begin
            gap++;
         end
      end
      checks++;
      if (busy()) begin failures++; $display("FAIL b2b_done got=still busy required=drained"); end
      checks++;
      if (grant_log.size() != 6) begin
         failures++;
         $display("FAIL b2b_grant_count got=%0d required=6", grant_log.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            if (grant_log[k] != (k % 2)) begin
               failures++;
               $display("FAIL b2b_grant_order idx=%0d got=%0d required=%0d", k, grant_log[k], k % 2);
               break;
            end
         end
      end
   endtask

   task automatic test_slverr();
      bit hs = 0;
      slv_wait = 0;
      err_addr = 32'hFC;
      grant_log.delete();
      push_cmd(0, 1'b1, 32'hFC, 32'h1234_5678);
      push_cmd(1, 1'b0, 32'h30, 32'h0);
      for (int c = 0; c < 20; c++) begin
         @(negedge PCLK);
         if (req_valid[0] && req_ready[0]) begin hs = 1; break; end
      end
      checks++;
      if (!hs) begin failures++; $display("FAIL slverr_accept got=no handshake required=handshake"); end
      repeat (3) @(negedge PCLK);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin
         failures++;
         $display("FAIL slverr_rsp got v=%b err=%b to=%b required 01 1 0", rsp_valid, rsp_err, rsp_timeout);
      end
      for (int c = 0; c < 50 && busy(); c++) @(negedge PCLK);
      checks++;
      if (busy() || grant_log.size() != 2) begin
         failures++;
         $display("FAIL slverr_next_served got grants=%0d required=2", grant_log.size());
      end
      err_addr = 32'hFFFF_FFF0;
   endtask

   task automatic test_timeout();
      bit hs = 0;
      int pen = 0;
      slv_wait = -1;
      push_cmd(0, 1'b0, 32'h40, 32'h0);
      for (int c = 0; c < 20; c++) begin
         @(negedge PCLK);
         if (req_valid[0] && req_ready[0]) begin hs = 1; break; end
      end
      checks++;
      if (!hs) begin failures++; $display("FAIL timeout_accept got=no handshake required=handshake"); end
      for (int c = 0; c < 60; c++) begin
         @(negedge PCLK);
         if (rsp_valid != 2'b00) break;
         if (PENABLE) pen++;
      end
      checks++;
      if (pen != 16) begin failures++; $display("FAIL timeout_access_cycles got=%0d required=16", pen); end
      checks++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 2'b01 || rsp_err !== 1'b1 ||
          rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL timeout_rsp got psel=%b pen=%b v=%b err=%b to=%b rd=%h required 0 0 01 1 1 0",
                  PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
      end
      for (int c = 0; c < 10 && busy(); c++) @(negedge PCLK);
   endtask

   task automatic test_reset_mid();
      bit hs = 0;
      bit saw = 0;
      exp_t dropped;
      slv_wait = -1;
      push_cmd(1, 1'b0, 32'h50, 32'h0);
      for (int c = 0; c < 20; c++) begin
         @(negedge PCLK);
         if (req_valid[1] && req_ready[1]) begin hs = 1; break; end
      end
      checks++;
      if (!hs) begin failures++; $display("FAIL rstmid_accept got=no handshake required=handshake"); end
      repeat (3) @(negedge PCLK);
      checks++;
      if (PENABLE !== 1'b1) begin failures++; $display("FAIL rstmid_in_access got pen=%b required=1", PENABLE); end
      PRESETn = 1'b0;
      @(posedge PCLK);
      if (exp_q.size() != 0) dropped = exp_q.pop_front();
      @(negedge PCLK);
      checks++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 2'b00) begin
         failures++;
         $display("FAIL rstmid_bus got psel=%b pen=%b v=%b required 0 0 00", PSEL, PENABLE, rsp_valid);
      end
      PRESETn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge PCLK);
         if (rsp_valid != 2'b00) saw = 1;
      end
      checks++;
      if (saw) begin failures++; $display("FAIL rstmid_no_rsp got=response required=none"); end
      slv_wait = 0;
      grant_log.delete();
      push_cmd(0, 1'b0, 32'h60, 32'h0);
      push_cmd(1, 1'b0, 32'h70, 32'h0);
      for (int c = 0; c < 50 && busy(); c++) @(negedge PCLK);
      checks++;
      if (busy() || grant_log.size() != 2 || grant_log[0] != 0) begin
         failures++;
         $display("FAIL rstmid_first_grant got grants=%0d first=%0d required 2 grants first=0",
                  grant_log.size(), (grant_log.size() != 0) ? grant_log[0] : -1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=simulation hung required=finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      PRESETn   = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      PRDATA    = '0;
      test_reset();
      test_single_write();
      test_read_wait();
      test_back_to_back();
      test_slverr();
      test_timeout();
      test_reset_mid();
      repeat (3) @(negedge PCLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
